// File: rtl/config_space_arbiter.sv
// Round-robin arbiter sharing the single config-space access port between two requesters.
// One transaction in flight; reads wait RD_LATENCY cycles before data returns to the winner.
//
// state | meaning
// IDLE  | nothing in flight; choose a requester (pointer breaks ties)
// ISSUE | one-cycle strobe toward config space, ready pulse to the winner
// WAIT  | read latency countdown; cfg_rdata captured on terminal count
// DONE  | one-cycle done pulse to the winner; pointer moves to the other side
module config_space_arbiter #(
  parameter int AW         = 8,
  parameter int DW         = 32,
  parameter int RD_LATENCY = 2
) (
  input  logic          local_clk,
  input  logic          rst,

  input  logic          rq0_valid,
  input  logic          rq0_write,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rq0_ready,
  output logic          rq0_done,
  output logic [DW-1:0] rq0_rdata,

  input  logic          rq1_valid,
  input  logic          rq1_write,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq1_ready,
  output logic          rq1_done,
  output logic [DW-1:0] rq1_rdata,

  output logic          cfg_read,
  output logic          cfg_write,
  output logic [AW-1:0] cfg_address,
  output logic [DW-1:0] cfg_wdata,
  input  logic [DW-1:0] cfg_rdata,

  output logic          busy
);

  localparam int CW = $clog2(RD_LATENCY + 1);
  localparam logic [CW-1:0] CNT_LOAD = CW'(RD_LATENCY);
  localparam logic [CW-1:0] CNT_TC   = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_nxt;
  logic          rr_ptr, rr_ptr_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          grant;
  logic          grant_id;
  logic          gnt_id;
  logic          lat_write;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          cap_rdata;

  always_ff @(posedge local_clk) begin
    if (!rst) begin
      state     <= IDLE;
      rr_ptr    <= 1'b0;
      cnt       <= '0;
      gnt_id    <= 1'b0;
      lat_write <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      rq0_rdata <= '0;
      rq1_rdata <= '0;
    end else begin
      state  <= state_nxt;
      rr_ptr <= rr_ptr_nxt;
      cnt    <= cnt_nxt;
      // Requester fields are frozen at grant so a requester may drop or change them afterwards.
      if (grant) begin
        gnt_id    <= grant_id;
        lat_write <= grant_id ? rq1_write : rq0_write;
        lat_addr  <= grant_id ? rq1_addr  : rq0_addr;
        lat_wdata <= grant_id ? rq1_wdata : rq0_wdata;
      end
      if (cap_rdata && !gnt_id) rq0_rdata <= cfg_rdata;
      if (cap_rdata &&  gnt_id) rq1_rdata <= cfg_rdata;
    end
  end

  assign cap_rdata = (state == WAIT) && (cnt == CNT_TC);

  always_comb begin
    state_nxt  = state;
    rr_ptr_nxt = rr_ptr;
    cnt_nxt    = cnt;
    grant      = 1'b0;
    grant_id   = 1'b0;
    case (state)
      IDLE: begin
        if (rq0_valid && (!rq1_valid || !rr_ptr)) begin
          grant    = 1'b1;
          grant_id = 1'b0;
        end else if (rq1_valid) begin
          grant    = 1'b1;
          grant_id = 1'b1;
        end
        if (grant) state_nxt = ISSUE;
      end
      ISSUE: begin
        if (lat_write) begin
          state_nxt = DONE;
        end else begin
          state_nxt = WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      WAIT: begin
        if (cnt == CNT_TC) state_nxt = DONE;
        else               cnt_nxt   = cnt - CNT_TC;
      end
      DONE: begin
        rr_ptr_nxt = ~gnt_id;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rq0_ready   = (state == ISSUE) && !gnt_id;
  assign rq1_ready   = (state == ISSUE) &&  gnt_id;
  assign rq0_done    = (state == DONE)  && !gnt_id;
  assign rq1_done    = (state == DONE)  &&  gnt_id;
  assign cfg_read    = (state == ISSUE) && !lat_write;
  assign cfg_write   = (state == ISSUE) &&  lat_write;
  assign cfg_address = (state == ISSUE) ? lat_addr : '0;
  assign cfg_wdata   = cfg_write ? lat_wdata : '0;
  assign busy        = (state != IDLE);

endmodule
